// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter with a transmit FIFO.
// CPU stores fill the FIFO; an FSM shifts bytes out as 8N1 (8E1) frames.
//
// Ports:
//   CLK, RST_N          clock, async active-low reset
//   D_CS, D_WE, D_ADDR  CPU data-side select, byte-lane enables, address
//   D_Mem_Bus           shared bidirectional data bus (driven on reads)
//   Rx                  serial output to host, idle high
//   tx_busy             frame in progress or FIFO non-empty
// Registers: 0x0 DATA (W), 0x4 STATUS (R/W1C), 0x8 DIV (R/W), 0xC rsvd.
// Build option: define UART_TX_PARITY_EN for an even-parity bit (8E1).
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
   parameter int          CLKS_PER_BIT = 868,
   parameter int          FIFO_DEPTH   = 16
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        D_CS,
   input  logic [3:0]  D_WE,
   input  logic [31:0] D_ADDR,
   inout  wire  [31:0] D_Mem_Bus,
   output logic        Rx,
   output logic        tx_busy
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [15:0] DIV_RST = 16'(CLKS_PER_BIT);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_STOP
   } state_t;
`endif

   state_t r_state;
   state_t w_nxt;

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          r_ovf;
   logic [15:0]   r_div;
   logic [15:0]   r_cnt;
   logic [7:0]    r_shift;
   logic [2:0]    r_bit;
`ifdef UART_TX_PARITY_EN
   logic          r_par;
`endif

   logic [31:0] w_bus_in;
   logic        w_match;
   logic        w_rd;
   logic        w_wr;
   logic [1:0]  w_sel;
   logic [31:0] w_rdata;
   logic        w_full;
   logic        w_empty;
   logic        w_active;
   logic        w_push_req;
   logic        w_push;
   logic        w_pop;
   logic        w_reload;
   logic        w_shift;
   logic        w_tick;
   logic [15:0] w_div_m1;
   logic [8:0]  w_cnt9;
   logic        w_unused;

   // Bus decode
   assign w_bus_in = D_Mem_Bus;
   assign w_match  = (D_ADDR[31:4] == BASE_ADDR[31:4]);
   assign w_sel    = D_ADDR[3:2];
   assign w_rd     = D_CS && (D_WE == 4'b0000) && w_match;
   assign w_wr     = D_CS && (|D_WE) && w_match;
   assign w_unused = ^{D_ADDR[1:0], D_WE[3:2], w_bus_in[31:16]};

   // FIFO status
   assign w_full   = (r_count == CW'(FIFO_DEPTH));
   assign w_empty  = (r_count == '0);
   assign w_active = (r_state != S_IDLE);
   assign w_cnt9   = 9'(r_count);
   assign tx_busy  = w_active || !w_empty;

   // A full FIFO still accepts a push if a pop frees a slot this cycle
   assign w_push_req = w_wr && (w_sel == 2'd0) && D_WE[0];
   assign w_push     = w_push_req && (!w_full || w_pop);

   // DIV==0 behaves as DIV==1
   assign w_div_m1 = (r_div == 16'd0) ? 16'd0 : r_div - 16'd1;
   assign w_tick   = (r_cnt == 16'd0);

   always_comb begin
      w_rdata = 32'd0;
      unique case (w_sel)
         2'd1: w_rdata = {15'd0, w_cnt9, 4'd0,
                          r_ovf, w_empty, w_full, w_active};
         2'd2: w_rdata = {16'd0, r_div};
         default: w_rdata = 32'd0;
      endcase
   end

   assign D_Mem_Bus = w_rd ? w_rdata : 32'bz;

   // Serializer next-state and line output
   always_comb begin
      w_nxt    = r_state;
      w_pop    = 1'b0;
      w_reload = 1'b0;
      w_shift  = 1'b0;
      Rx       = 1'b1;
      unique case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop    = 1'b1;
               w_reload = 1'b1;
               w_nxt    = S_START;
            end
         end
         S_START: begin
            Rx = 1'b0;
            if (w_tick) begin
               w_reload = 1'b1;
               w_nxt    = S_DATA;
            end
         end
         S_DATA: begin
            Rx = r_shift[0];
            if (w_tick) begin
               w_reload = 1'b1;
               w_shift  = 1'b1;
               if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  w_nxt = S_PARITY;
`else
                  w_nxt = S_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            Rx = r_par;
            if (w_tick) begin
               w_reload = 1'b1;
               w_nxt    = S_STOP;
            end
         end
`endif
         S_STOP: begin
            Rx = 1'b1;
            if (w_tick) begin
               w_reload = 1'b1;
               // Chain straight into the next start bit
               if (!w_empty) begin
                  w_pop = 1'b1;
                  w_nxt = S_START;
               end else begin
                  w_nxt = S_IDLE;
               end
            end
         end
         default: w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nxt;
      end
   end

   // Bit timer and shifter; DIV is sampled only at reload
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_cnt   <= 16'd0;
         r_shift <= 8'd0;
         r_bit   <= 3'd0;
`ifdef UART_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         if (w_reload) begin
            r_cnt <= w_div_m1;
         end else if (!w_tick) begin
            r_cnt <= r_cnt - 16'd1;
         end
         if (w_pop) begin
            r_shift <= r_mem[r_rptr];
            r_bit   <= 3'd0;
`ifdef UART_TX_PARITY_EN
            r_par   <= ^r_mem[r_rptr];
`endif
         end else if (w_shift) begin
            r_shift <= {1'b0, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_mem[r_wptr] <= w_bus_in[7:0];
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   // Control registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_ovf <= 1'b0;
         r_div <= DIV_RST;
      end else begin
         if (w_push_req && !w_push) begin
            r_ovf <= 1'b1;
         end else if (w_wr && (w_sel == 2'd1) && D_WE[0] && w_bus_in[3]) begin
            r_ovf <= 1'b0;
         end
         if (w_wr && (w_sel == 2'd2)) begin
            if (D_WE[0]) r_div[7:0]  <= w_bus_in[7:0];
            if (D_WE[1]) r_div[15:8] <= w_bus_in[15:8];
         end
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed self-checking bench for mmio_uart_tx.
// Bus idle level is observed through a pull-up on D_Mem_Bus.
module tb_mmio_uart_tx;

`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
   localparam logic [10:0] SEQ_A5 = 11'b101_0100_1010;
`else
   localparam int NB = 10;
   localparam logic [10:0] SEQ_A5 = 11'b011_0100_1010;
`endif

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        D_CS = 1'b0;
   logic [3:0]  D_WE = 4'd0;
   logic [31:0] D_ADDR = 32'd0;
   wire  [31:0] D_Mem_Bus;
   logic        Rx;
   logic        tx_busy;
   logic        r_drv = 1'b0;
   logic [31:0] r_wd = 32'd0;
   logic [31:0] rv;
   logic [10:0] seq;
   int          total = 0;
   int          bad = 0;

   always #5 CLK = ~CLK;

   assign D_Mem_Bus = r_drv ? r_wd : 32'bz;
   pullup (D_Mem_Bus);

   mmio_uart_tx #(
      .BASE_ADDR(32'h0000_0400),
      .CLKS_PER_BIT(868),
      .FIFO_DEPTH(16)
   ) dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .D_CS(D_CS),
      .D_WE(D_WE),
      .D_ADDR(D_ADDR),
      .D_Mem_Bus(D_Mem_Bus),
      .Rx(Rx),
      .tx_busy(tx_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] req);
      total++;
      assert (obs === req) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, req);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] we,
                     input logic [31:0] d);
      @(negedge CLK);
      D_CS = 1'b1; D_WE = we; D_ADDR = a; r_wd = d; r_drv = 1'b1;
      @(posedge CLK);
      #1;
      D_CS = 1'b0; D_WE = 4'd0; r_drv = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      @(negedge CLK);
      D_CS = 1'b1; D_WE = 4'd0; D_ADDR = a;
      #1;
      d = D_Mem_Bus;
      D_CS = 1'b0;
   endtask

   task automatic wait_idle(input int lim, input string tag);
      int n = 0;
      while (tx_busy !== 1'b0 && n < lim) begin
         @(posedge CLK);
         #1;
         n++;
      end
      chk(tag, {31'd0, tx_busy}, 32'd0);
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_rx", {31'd0, Rx}, 32'd1);
      chk("rst_busy", {31'd0, tx_busy}, 32'd0);
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      rd(32'h404, rv); chk("rst_status", rv, 32'h4);
      rd(32'h408, rv); chk("rst_div", rv, 32'd868);
      rd(32'h400, rv); chk("rd_data0", rv, 32'd0);
      rd(32'h40C, rv); chk("rd_rsvd", rv, 32'd0);
      #1;
      chk("bus_hiz_nocs", D_Mem_Bus, 32'hFFFF_FFFF);
      rd(32'h504, rv); chk("bus_hiz_miss", rv, 32'hFFFF_FFFF);

      // DIV upper-lane write only
      wr(32'h408, 4'b0010, 32'h0000_0200);
      rd(32'h408, rv); chk("div_lane1", rv, 32'h0000_0264);

      // Single frame A5 at DIV=4
      wr(32'h408, 4'b0011, 32'd4);
      rd(32'h408, rv); chk("div4", rv, 32'd4);
      seq = SEQ_A5;
      wr(32'h400, 4'b0001, 32'hA5);
      chk("a5_busy_N", {31'd0, tx_busy}, 32'd1);
      chk("a5_rx_N", {31'd0, Rx}, 32'd1);
      rd(32'h404, rv); chk("a5_status_N", rv, 32'h0000_0100);
      @(posedge CLK); #1;
      chk("a5_start_edge", {31'd0, Rx}, 32'd0);
      @(posedge CLK);
      @(posedge CLK); #1;
      chk("a5_bit0", {31'd0, Rx}, {31'd0, seq[0]});
      for (int k = 1; k < NB; k++) begin
         repeat (4) @(posedge CLK);
         #1;
         chk($sformatf("a5_bit%0d", k), {31'd0, Rx}, {31'd0, seq[k]});
      end
      @(posedge CLK); #1;
      chk("a5_busy_last", {31'd0, tx_busy}, 32'd1);
      @(posedge CLK); #1;
      chk("a5_busy_fall", {31'd0, tx_busy}, 32'd0);

      // Overflow at DIV=2: 18 back-to-back pushes, one popped, one dropped
      wr(32'h408, 4'b0011, 32'd2);
      for (int i = 0; i < 18; i++) begin
         wr(32'h400, 4'b0001, 32'(i));
      end
      rd(32'h404, rv); chk("ovf_status", rv, 32'h0000_100B);
      wr(32'h404, 4'b0001, 32'h8);
      rd(32'h404, rv); chk("ovf_clear", rv, 32'h0000_1003);
      wait_idle(2000, "ovf_drain");
      rd(32'h404, rv); chk("ovf_after", rv, 32'h4);

      // Back-to-back 00, FF at DIV=3
      wr(32'h408, 4'b0011, 32'd3);
      wr(32'h400, 4'b0001, 32'h00);
      wr(32'h400, 4'b0001, 32'hFF);
      chk("b2b_start1", {31'd0, Rx}, 32'd0);
      repeat (3 * NB - 3) @(posedge CLK);
      #1;
      chk("b2b_stop_first", {31'd0, Rx}, 32'd1);
      repeat (2) @(posedge CLK);
      #1;
      chk("b2b_stop_last", {31'd0, Rx}, 32'd1);
      @(posedge CLK); #1;
      chk("b2b_start2", {31'd0, Rx}, 32'd0);
      chk("b2b_busy", {31'd0, tx_busy}, 32'd1);
      repeat (4) @(posedge CLK);
      #1;
      chk("b2b_ff_bit0", {31'd0, Rx}, 32'd1);
      wait_idle(500, "b2b_drain");

      // DIV=0 behaves as DIV=1
      wr(32'h408, 4'b0011, 32'd0);
      wr(32'h400, 4'b0001, 32'h01);
      @(posedge CLK); #1;
      chk("div0_start", {31'd0, Rx}, 32'd0);
      @(posedge CLK); #1;
      chk("div0_bit0", {31'd0, Rx}, 32'd1);
      @(posedge CLK); #1;
      chk("div0_bit1", {31'd0, Rx}, 32'd0);
      repeat (NB - 3) @(posedge CLK);
      #1;
      chk("div0_stop_busy", {31'd0, tx_busy}, 32'd1);
      chk("div0_stop_rx", {31'd0, Rx}, 32'd1);
      @(posedge CLK); #1;
      chk("div0_busy_fall", {31'd0, tx_busy}, 32'd0);

      // Reset during data bit 3
      wr(32'h408, 4'b0011, 32'd3);
      wr(32'h400, 4'b0001, 32'h00);
      wr(32'h400, 4'b0001, 32'h11);
      wr(32'h400, 4'b0001, 32'h22);
      repeat (11) @(posedge CLK);
      #1;
      chk("mid_bit3", {31'd0, Rx}, 32'd0);
      RST_N = 1'b0;
      #1;
      chk("mid_rst_rx", {31'd0, Rx}, 32'd1);
      chk("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      rd(32'h404, rv); chk("post_rst_status", rv, 32'h4);
      rd(32'h408, rv); chk("post_rst_div", rv, 32'd868);
      repeat (5) @(posedge CLK);
      #1;
      chk("post_rst_rx", {31'd0, Rx}, 32'd1);
      chk("post_rst_busy", {31'd0, tx_busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
